// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm unit: FSM state, BCD digit limits, one-hot digit selects.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alarm_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SET     = 2'd1,
      RINGING = 2'd2,
      SNOOZED = 2'd3
   } alarm_state_t;

   // Largest legal value of each BCD digit before it wraps to 0
   localparam logic [3:0] MIN_T_MAX   = 4'd5;
   localparam logic [3:0] HR_T_MAX    = 4'd2;
   localparam logic [3:0] HR_U_MAX_24 = 4'd3;   // hrU limit while hrT==2 (20..23)
   localparam logic [3:0] DIG_MAX     = 4'd9;

   // One-hot digit select, bit order {hrT,hrU,minT,minU}
   localparam logic [3:0] SEL_MIN_U = 4'b0001;
   localparam logic [3:0] SEL_MIN_T = 4'b0010;
   localparam logic [3:0] SEL_HR_U  = 4'b0100;
   localparam logic [3:0] SEL_HR_T  = 4'b1000;

   // Rotate the one-hot select one position left, hrT wraps back to minU
   function automatic logic [3:0] rotSel(input logic [3:0] s);
      return {s[2:0], s[3]};
   endfunction

endpackage

// File: rtl/alarm_digit_reg.sv
// One BCD alarm digit: clears, or increments with wrap at a runtime-supplied maximum.
// Latency: new value visible the cycle after inc/clr.
// Backpressure: none; inc and clr are single-cycle strobes consumed immediately.
//
// Ports: clk, resetn (async active-low), inc (add one), clr (force 0, wins over inc),
//        maxVal (value after which the digit wraps to 0), q (stored digit).
module alarm_digit_reg (
   input  logic       clk,
   input  logic       resetn,
   input  logic       inc,
   input  logic       clr,
   input  logic [3:0] maxVal,
   output logic [3:0] q
);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (inc) begin
         // >= rather than == so an out-of-range value still recovers to 0
         q <= (q >= maxVal) ? 4'd0 : q + 4'd1;
      end
   end

endmodule

// File: rtl/alarm_unit.sv
// Alarm unit: user-settable HH:MM alarm compared against the running BCD time, rings at HH:MM:00.
// Latency: ringing rises 1 cycle after the time reaches HH:MM:00; stop/snooze act on the next cycle.
// Backpressure: none; all control inputs are single-cycle pulses or levels sampled every cycle.
//
// Ports: clk, resetn (async active-low), sec_tick (1 s pulse), secU/secT/minU/minT/hrU/hrT (current
//        time BCD), alarm_en (armed level), set_alarm (set-mode level), switch_select / increment
//        (digit edit pulses), stop / snooze (pulses); outputs almMinU/almMinT/almHrU/almHrT (stored
//        alarm), sel (one-hot digit being edited, 0 outside SET), ringing, buzzer.
// Build option: define ALARM_BEEP_EN for an intermittent buzzer (BEEP_HALF cycles on, BEEP_HALF off);
//        without it the buzzer follows ringing continuously.
module alarm_unit
   import alarm_pkg::*;
#(
   parameter int unsigned SNOOZE_MIN = 5,
   parameter int unsigned RING_SEC   = 60,
   parameter int unsigned BEEP_HALF  = 25_000_000
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       sec_tick,
   input  logic [3:0] secU,
   input  logic [3:0] secT,
   input  logic [3:0] minU,
   input  logic [3:0] minT,
   input  logic [3:0] hrU,
   input  logic [3:0] hrT,
   input  logic       alarm_en,
   input  logic       set_alarm,
   input  logic       switch_select,
   input  logic       increment,
   input  logic       stop,
   input  logic       snooze,
   output logic [3:0] almMinU,
   output logic [3:0] almMinT,
   output logic [3:0] almHrU,
   output logic [3:0] almHrT,
   output logic [3:0] sel,
   output logic       ringing,
   output logic       buzzer
);

   localparam logic [9:0] SnzLoad  = 10'(SNOOZE_MIN * 60);
   localparam logic [8:0] RingLast = 9'(RING_SEC);

   alarm_state_t state;
   alarm_state_t stateNxt;
   logic         match;
   logic         matchQ;
   logic         trigger;
   logic [7:0]   ringCnt;
   logic [9:0]   snzCnt;
   logic         ringTimeout;
   logic         incEn;
   logic         incMinU, incMinT, incHrU, incHrT;
   logic         clrHrU;
   logic [3:0]   hrUMax;

   // ---------------- time compare ----------------
   assign match = (almHrT == hrT) && (almHrU == hrU) && (almMinT == minT) && (almMinU == minU) &&
                  (secT == 4'd0) && (secU == 4'd0);
   // Rising edge only: holding HH:MM:00 for many cycles, or arriving there while already matched
   // (e.g. by editing the alarm onto the current time), never produces a second fire.
   assign trigger = match && !matchQ;

   assign ringTimeout = ({1'b0, ringCnt} + 9'd1) == RingLast;

   // ---------------- digit editing ----------------
   assign incEn   = (state == SET) && set_alarm && increment;
   assign incMinU = incEn && sel[0];
   assign incMinT = incEn && sel[1];
   assign incHrU  = incEn && sel[2];
   assign incHrT  = incEn && sel[3];
   assign hrUMax  = (almHrT == HR_T_MAX) ? HR_U_MAX_24 : DIG_MAX;
   // hrT stepping 1->2 would make 24..29 legal-looking; drop hrU to 0 in the same cycle
   assign clrHrU  = incHrT && (almHrT == HR_T_MAX - 4'd1) && (almHrU > HR_U_MAX_24);

   alarm_digit_reg uMinU (.clk(clk), .resetn(resetn), .inc(incMinU), .clr(1'b0),
                          .maxVal(DIG_MAX), .q(almMinU));
   alarm_digit_reg uMinT (.clk(clk), .resetn(resetn), .inc(incMinT), .clr(1'b0),
                          .maxVal(MIN_T_MAX), .q(almMinT));
   alarm_digit_reg uHrU  (.clk(clk), .resetn(resetn), .inc(incHrU), .clr(clrHrU),
                          .maxVal(hrUMax), .q(almHrU));
   alarm_digit_reg uHrT  (.clk(clk), .resetn(resetn), .inc(incHrT), .clr(1'b0),
                          .maxVal(HR_T_MAX), .q(almHrT));

   // ---------------- next state ----------------
   // Order of precedence: set_alarm, stop, alarm_en low, snooze, then tick/trigger.
   always_comb begin
      stateNxt = state;
      case (state)
         IDLE: begin
            if (set_alarm)                          stateNxt = SET;
            else if (!stop && alarm_en && trigger)  stateNxt = RINGING;
         end
         SET: begin
            if (!set_alarm)                         stateNxt = IDLE;
         end
         RINGING: begin
            if (set_alarm)                          stateNxt = SET;
            else if (stop || !alarm_en)             stateNxt = IDLE;
            else if (snooze)                        stateNxt = SNOOZED;
            else if (sec_tick && ringTimeout)       stateNxt = IDLE;
         end
         SNOOZED: begin
            if (set_alarm)                          stateNxt = SET;
            else if (stop || !alarm_en)             stateNxt = IDLE;
            else if (sec_tick && snzCnt <= 10'd1)   stateNxt = RINGING;
         end
         default:                                   stateNxt = IDLE;
      endcase
   end

   // ---------------- state, outputs, counters ----------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state   <= IDLE;
         matchQ  <= 1'b0;
         ringing <= 1'b0;
         sel     <= '0;
         ringCnt <= '0;
         snzCnt  <= '0;
      end else begin
         state   <= stateNxt;
         matchQ  <= match;
         ringing <= (stateNxt == RINGING);

         // Edit pulse and select pulse together: the digit logic already used the old sel
         if (stateNxt == SET) begin
            if (state != SET)          sel <= SEL_MIN_U;
            else if (switch_select)    sel <= rotSel(sel);
         end else begin
            sel <= '0;
         end

         if (stateNxt == RINGING && state != RINGING) begin
            ringCnt <= '0;
         end else if (state == RINGING && sec_tick && ringCnt != 8'hFF) begin
            ringCnt <= ringCnt + 8'd1;
         end

         if (stateNxt == SNOOZED && state != SNOOZED) begin
            snzCnt <= SnzLoad;
         end else if (state == SNOOZED && sec_tick && snzCnt != 10'd0) begin
            snzCnt <= snzCnt - 10'd1;
         end
      end
   end

   // ---------------- buzzer ----------------
`ifdef ALARM_BEEP_EN
   localparam logic [24:0] BeepLast = 25'(BEEP_HALF - 1);

   logic [24:0] beepCnt;
   logic        phase;

   // Tracks stateNxt so phase lines up with the registered ringing output
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         beepCnt <= '0;
         phase   <= 1'b0;
      end else if (stateNxt == RINGING && state != RINGING) begin
         beepCnt <= '0;
         phase   <= 1'b1;
      end else if (stateNxt == RINGING) begin
         if (beepCnt == BeepLast) begin
            beepCnt <= '0;
            phase   <= ~phase;
         end else begin
            beepCnt <= beepCnt + 25'd1;
         end
      end else begin
         beepCnt <= '0;
         phase   <= 1'b0;
      end
   end

   assign buzzer = ringing & phase;
`else
   assign buzzer = ringing;
`endif

endmodule

// File: tb/tb_alarm_unit.sv
// Self-checking bench for alarm_unit: directed steps plus randomized alarm edits/fires,
// checked against a digit-level arithmetic model of the alarm setting.
module tb_alarm_unit;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       sec_tick = 1'b0;
   logic [3:0] secU = '0, secT = '0, minU = '0, minT = '0, hrU = '0, hrT = '0;
   logic       alarm_en = 1'b0, set_alarm = 1'b0, switch_select = 1'b0;
   logic       increment = 1'b0, stop = 1'b0, snooze = 1'b0;
   logic [3:0] almMinU, almMinT, almHrU, almHrT, sel;
   logic       ringing, buzzer;

   alarm_unit #(.SNOOZE_MIN(1), .RING_SEC(60), .BEEP_HALF(4)) dut (
      .clk(clk), .resetn(resetn), .sec_tick(sec_tick),
      .secU(secU), .secT(secT), .minU(minU), .minT(minT), .hrU(hrU), .hrT(hrT),
      .alarm_en(alarm_en), .set_alarm(set_alarm), .switch_select(switch_select),
      .increment(increment), .stop(stop), .snooze(snooze),
      .almMinU(almMinU), .almMinT(almMinT), .almHrU(almHrU), .almHrT(almHrT),
      .sel(sel), .ringing(ringing), .buzzer(buzzer)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   // Reference model of the stored alarm and the edit cursor (-1 = not in set mode)
   int mU = 0, mT = 0, hU = 0, hT = 0;
   int selIdx = -1;

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic void modelInc();
      case (selIdx)
         0: mU = (mU + 1) % 10;
         1: mT = (mT + 1) % 6;
         2: hU = (hT == 2) ? (hU + 1) % 4 : (hU + 1) % 10;
         3: begin
            hT = (hT + 1) % 3;
            if (hT == 2 && hU > 3) hU = 0;
         end
         default: ;
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulseSel();
      switch_select = 1'b1; step(); switch_select = 1'b0;
      selIdx = (selIdx + 1) % 4;
   endtask

   task automatic pulseInc();
      increment = 1'b1; step(); increment = 1'b0;
      modelInc();
   endtask

   task automatic pulseTick();
      sec_tick = 1'b1; step(); sec_tick = 1'b0;
   endtask

   task automatic pulseStop();
      stop = 1'b1; step(); stop = 1'b0;
   endtask

   task automatic pulseSnooze();
      snooze = 1'b1; step(); snooze = 1'b0;
   endtask

   task automatic setTime(input int h, input int m, input int s);
      hrT = 4'(h / 10); hrU = 4'(h % 10);
      minT = 4'(m / 10); minU = 4'(m % 10);
      secT = 4'(s / 10); secU = 4'(s % 10);
   endtask

   task automatic checkDigits(input string tag);
      chk({tag, "_minU"}, int'(almMinU), mU);
      chk({tag, "_minT"}, int'(almMinT), mT);
      chk({tag, "_hrU"},  int'(almHrU),  hU);
      chk({tag, "_hrT"},  int'(almHrT),  hT);
   endtask

   task automatic checkSel(input string tag);
      chk(tag, int'(sel), (selIdx < 0) ? 0 : (1 << selIdx));
   endtask

   task automatic chkRing(input string tag, input int e);
      chk({tag, "_ringing"}, int'(ringing), e);
`ifndef ALARM_BEEP_EN
      chk({tag, "_buzzer"}, int'(buzzer), e);
`else
      if (e == 0) chk({tag, "_buzzer"}, int'(buzzer), 0);
`endif
   endtask

   // Approach HH:MM:00 from inside the same minute, then land on it
   task automatic fire(input string tag, input int h, input int m);
      setTime(h, m, 1);
      step();
      setTime(h, m, 0);
      chkRing({tag, "_pre"}, 0);
      step();
      chkRing(tag, 1);
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int rang;

      // ---- reset state ----
      repeat (2) @(posedge clk);
      #1;
      chkRing("reset", 0);
      checkSel("reset_sel");
      checkDigits("reset");
      resetn = 1'b1;
      step();

      // ---- set 07:30 ----
      set_alarm = 1'b1; selIdx = 0;
      step();
      checkSel("set_entry");
      pulseSel();
      repeat (3) pulseInc();
      pulseSel();
      repeat (7) pulseInc();
      checkDigits("set0730");
      chk("set0730_hrU_literal", int'(almHrU), 7);
      set_alarm = 1'b0; selIdx = -1;
      step();
      checkSel("set_exit");

      // ---- fire at 07:30:00, one cycle latency, single fire per minute ----
      alarm_en = 1'b1;
      setTime(7, 29, 59);
      repeat (3) step();
      chkRing("pre_minute", 0);
      setTime(7, 30, 0);
      chkRing("same_cycle", 0);
      step();
      chkRing("fire1", 1);
`ifdef ALARM_BEEP_EN
      for (int k = 0; k < 16; k++) begin
         chk($sformatf("beep_k%0d", k), int'(buzzer), ((k / 4) % 2 == 0) ? 1 : 0);
         step();
      end
`endif
      pulseStop();
      chkRing("stop1", 0);
      repeat (4) step();
      chkRing("hold_00", 0);
      rang = 0;
      for (int s = 1; s < 60; s++) begin
         setTime(7, 30, s);
         step();
         if (ringing) rang = 1;
      end
      chk("no_refire", rang, 0);
      setTime(7, 31, 0);
      step();
      chkRing("next_minute", 0);

      // ---- snooze (1 minute) ----
      fire("fire2", 7, 30);
      pulseSnooze();
      chkRing("snoozed", 0);
      repeat (59) pulseTick();
      chkRing("snz59", 0);
      pulseTick();
      chkRing("snz60", 1);
      pulseStop();
      chkRing("stop2", 0);

      // ---- auto timeout and stop+snooze ----
      fire("fire3", 7, 30);
      repeat (59) pulseTick();
      chkRing("ring59", 1);
      pulseTick();
      chkRing("timeout", 0);
      fire("fire4", 7, 30);
      stop = 1'b1; snooze = 1'b1;
      step();
      stop = 1'b0; snooze = 1'b0;
      chkRing("stop_snooze", 0);
      repeat (60) pulseTick();
      chkRing("no_snooze_resume", 0);

      // ---- digit wrap rules ----
      set_alarm = 1'b1; selIdx = 0;
      step();
      repeat (3) pulseSel();
      checkSel("sel_hrT");
      pulseInc();
      pulseInc();
      checkDigits("hrT2");
      chk("hrU_cleared", int'(almHrU), 0);
      pulseSel();
      checkSel("sel_wrap");
      pulseSel(); pulseSel();
      repeat (3) pulseInc();
      chk("hrU_3", int'(almHrU), 3);
      pulseInc();
      chk("hrU_wrap24", int'(almHrU), 0);
      repeat (3) pulseSel();
      checkSel("sel_minT");
      repeat (2) pulseInc();
      pulseInc();
      chk("minT_wrap", int'(almMinT), 0);
      switch_select = 1'b1; increment = 1'b1;
      step();
      switch_select = 1'b0; increment = 1'b0;
      modelInc();
      selIdx = (selIdx + 1) % 4;
      checkDigits("both_pulses");
      checkSel("both_pulses_sel");
      set_alarm = 1'b0; selIdx = -1;
      step();

      // ---- alarm disabled / set mode at the match instant ----
      alarm_en = 1'b0;
      setTime(hT * 10 + hU, mT * 10 + mU, 1);
      step();
      setTime(hT * 10 + hU, mT * 10 + mU, 0);
      repeat (2) step();
      chkRing("disabled", 0);
      alarm_en = 1'b1;
      step();
      chkRing("enable_late", 0);
      setTime(hT * 10 + hU, mT * 10 + mU, 1);
      step();
      setTime(hT * 10 + hU, mT * 10 + mU, 0);
      set_alarm = 1'b1; selIdx = 0;
      step();
      chkRing("set_at_match", 0);
      checkSel("set_at_match_sel");
      set_alarm = 1'b0; selIdx = -1;
      step();
      chkRing("after_set", 0);

      // ---- async reset mid-ring ----
      fire("fire5", hT * 10 + hU, mT * 10 + mU);
      resetn = 1'b0;
      #1;
      mU = 0; mT = 0; hU = 0; hT = 0;
      chkRing("arst", 0);
      checkSel("arst_sel");
      checkDigits("arst");
      step();
      resetn = 1'b1;
      step();

      // ---- randomized edit sequences, each followed by a fire ----
      for (int it = 0; it < 6; it++) begin
         set_alarm = 1'b1; selIdx = 0;
         step();
         for (int op = 0; op < 25; op++) begin
            case ($urandom_range(0, 3))
               0: pulseSel();
               1: pulseInc();
               2: begin
                  switch_select = 1'b1; increment = 1'b1;
                  step();
                  switch_select = 1'b0; increment = 1'b0;
                  modelInc();
                  selIdx = (selIdx + 1) % 4;
               end
               default: step();
            endcase
         end
         checkDigits($sformatf("rnd%0d", it));
         checkSel($sformatf("rnd%0d_sel", it));
         set_alarm = 1'b0; selIdx = -1;
         step();
         fire($sformatf("rnd%0d_fire", it), hT * 10 + hU, mT * 10 + mU);
         if ($urandom_range(0, 1) == 0) begin
            pulseSnooze();
            repeat (60) pulseTick();
            chkRing($sformatf("rnd%0d_resnz", it), 1);
         end
         pulseStop();
         chkRing($sformatf("rnd%0d_stop", it), 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
